// File: rtl/irq_pending_latch.sv
// irq_pending_latch: synchronise four request lines, latch rising edges as pending events until acknowledged
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   irq_in[3:0]         asynchronous request lines, bit i is channel i
//   mask[3:0]           per-channel visibility on d0..d3
//   ack_valid, ack_code consumer serviced channel ack_code this cycle
//   ovf_clr             clears all overflow flags
//   d0..d3              pending & mask, feeds the priority encoder
//   pend_cnt            registered popcount of pending (unmasked)
//   ovf[3:0]            sticky: an edge arrived while the channel was already pending
// Optional: define IRQ_LEVEL_MODE_EN to add level_sel[3:0]; selected channels track the synchronised level.
module irq_pending_latch #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       irq_in,
    input  logic [3:0]       mask,
    input  logic             ack_valid,
    input  logic [1:0]       ack_code,
    input  logic             ovf_clr,
`ifdef IRQ_LEVEL_MODE_EN
    input  logic [3:0]       level_sel,
`endif
    output logic             d0,
    output logic             d1,
    output logic             d2,
    output logic             d3,
    output logic [CNT_W-1:0] pend_cnt,
    output logic [3:0]       ovf
);
    logic [3:0]       sync_q [SYNC_STAGES];
    logic [3:0]       prev_q, pend_q, pend_d, ovf_q, ovf_d;
    logic [3:0]       s, rise, ack_hit, lvl;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef IRQ_LEVEL_MODE_EN
    assign lvl = level_sel;
`else
    assign lvl = 4'b0;
`endif
    assign s       = sync_q[SYNC_STAGES-1];
    assign rise    = s & ~prev_q;
    assign ack_hit = ack_valid ? 4'b1 << ack_code : 4'b0;
    // A fresh edge on the serviced channel replaces the serviced event, so it is not an overflow.
    always_comb begin
        pend_d = (lvl & s) | (~lvl & (rise | (pend_q & ~ack_hit)));
        ovf_d  = ~lvl & ((rise & pend_q & ~ack_hit) | (ovf_q & ~{4{ovf_clr}}));
        cnt_d  = CNT_W'(pend_d[0]) + CNT_W'(pend_d[1]) + CNT_W'(pend_d[2]) + CNT_W'(pend_d[3]);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            prev_q <= '0;
            pend_q <= '0;
            ovf_q  <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            prev_q <= s;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
        end
    end
    assign {d3, d2, d1, d0} = pend_q & mask;
    assign pend_cnt         = cnt_q;
    assign ovf              = ovf_q;
endmodule

// File: tb/tb_irq_pending_latch.sv
// tb_irq_pending_latch: directed self-checking bench for irq_pending_latch
module tb_irq_pending_latch;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] irq_in = 4'b0;
    logic [3:0] mask = 4'b1111;
    logic       ack_valid = 1'b0;
    logic [1:0] ack_code = 2'd0;
    logic       ovf_clr = 1'b0;
    logic       d0, d1, d2, d3;
    logic [2:0] pend_cnt;
    logic [3:0] ovf;
`ifdef IRQ_LEVEL_MODE_EN
    logic [3:0] level_sel = 4'b0;
`endif
    int vectors = 0;
    int miscompares = 0;

    irq_pending_latch dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask(mask),
        .ack_valid(ack_valid), .ack_code(ack_code), .ovf_clr(ovf_clr),
`ifdef IRQ_LEVEL_MODE_EN
        .level_sel(level_sel),
`endif
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .pend_cnt(pend_cnt), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [3:0] ed, input logic [2:0] ec, input logic [3:0] eo);
        logic [10:0] obs, exp;
        obs = {ovf, pend_cnt, d3, d2, d1, d0};
        exp = {eo, ec, ed};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed ovf=%b cnt=%0d d=%b expected ovf=%b cnt=%0d d=%b",
                   tag, obs[10:7], obs[6:4], obs[3:0], eo, ec, ed);
        end
    endtask

    task automatic pulse(input logic [3:0] v);
        irq_in = v;
        tick();
        irq_in = 4'b0;
    endtask

    task automatic ack(input logic [1:0] c);
        ack_valid = 1'b1;
        ack_code  = c;
        tick();
        ack_valid = 1'b0;
    endtask

    initial begin
        tick();
        chk("reset", 4'b0000, 3'd0, 4'b0000);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle", 4'b0000, 3'd0, 4'b0000);
        end
        // latency: driven after edge M, pending after edge M+3
        pulse(4'b0100);
        chk("lat_e1", 4'b0000, 3'd0, 4'b0000);
        tick();
        chk("lat_e2", 4'b0000, 3'd0, 4'b0000);
        tick();
        chk("lat_e3", 4'b0100, 3'd1, 4'b0000);
        tick();
        chk("lat_hold", 4'b0100, 3'd1, 4'b0000);
        ack(2'd2);
        chk("lat_ack", 4'b0000, 3'd0, 4'b0000);
        // ack of a non-pending channel does nothing
        ack(2'd1);
        chk("ack_idle", 4'b0000, 3'd0, 4'b0000);
        // multi-channel with mask
        mask = 4'b0111;
        pulse(4'b1101);
        tick();
        tick();
        chk("mask_0111", 4'b0101, 3'd3, 4'b0000);
        mask = 4'b1111;
        #1;
        chk("unmask_comb", 4'b1101, 3'd3, 4'b0000);
        tick();
        ack(2'd0);
        chk("ack_ch0", 4'b1100, 3'd2, 4'b0000);
        ack(2'd2);
        ack(2'd3);
        chk("ack_all", 4'b0000, 3'd0, 4'b0000);
        // overflow on channel 1
        pulse(4'b0010);
        tick();
        tick();
        chk("ovf_first", 4'b0010, 3'd1, 4'b0000);
        pulse(4'b0010);
        tick();
        tick();
        chk("ovf_set", 4'b0010, 3'd1, 4'b0010);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", 4'b0010, 3'd1, 4'b0000);
        // clear and a new overflow in the same cycle: overflow wins
        pulse(4'b0010);
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr_race", 4'b0010, 3'd1, 4'b0010);
        ovf_clr = 1'b1;
        ack(2'd1);
        ovf_clr = 1'b0;
        chk("ovf_clean", 4'b0000, 3'd0, 4'b0000);
        // edge meets ack on channel 3
        pulse(4'b1000);
        tick();
        tick();
        chk("em_first", 4'b1000, 3'd1, 4'b0000);
        pulse(4'b1000);
        tick();
        ack(2'd3);
        chk("edge_meets_ack", 4'b1000, 3'd1, 4'b0000);
        ack(2'd3);
        chk("em_clear", 4'b0000, 3'd0, 4'b0000);
        // reset mid-operation
        pulse(4'b0011);
        tick();
        tick();
        pulse(4'b0001);
        tick();
        tick();
        chk("pre_reset", 4'b0011, 3'd2, 4'b0001);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 4'b0000, 3'd0, 4'b0000);
        #1 rst_n = 1'b1;
        tick();
        chk("post_reset", 4'b0000, 3'd0, 4'b0000);
        // reset release with the line already high, then held high: one event only
        rst_n = 1'b0;
        irq_in = 4'b0100;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("rel_high", 4'b0100, 3'd1, 4'b0000);
        for (int i = 0; i < 4; i++) tick();
        chk("level_once", 4'b0100, 3'd1, 4'b0000);
        ack(2'd2);
        chk("held_acked", 4'b0000, 3'd0, 4'b0000);
        irq_in = 4'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("held_low", 4'b0000, 3'd0, 4'b0000);
`ifdef IRQ_LEVEL_MODE_EN
        level_sel = 4'b0001;
        irq_in = 4'b0001;
        tick();
        tick();
        tick();
        chk("lvl_set", 4'b0001, 3'd1, 4'b0000);
        ack(2'd0);
        chk("lvl_ack", 4'b0001, 3'd1, 4'b0000);
        irq_in = 4'b0;
        tick();
        tick();
        tick();
        chk("lvl_drop", 4'b0000, 3'd0, 4'b0000);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
